// File: rtl/steer_en_ctrl.sv
// Rider-presence / steering-enable sequencer: samples the load cells, runs IDLE/WAIT/STEER with a settle timer.
// Build option: define STEER_HYST_EN to give the rider drop-out threshold a hysteresis margin.
//
// state | meaning
// IDLE  | no rider; integrator held clear, steering disabled
// WAIT  | rider present, waiting for balanced load to settle
// STEER | rider settled; steering enabled

module steer_en_ctrl #(
  parameter bit          fast_sim      = 1'b1,
  parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
  parameter logic [11:0] WT_HYSTERESIS = 12'h40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_vld,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  output logic        rider_off,
  output logic        en_steer,
  output logic [1:0]  steer_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEER = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [11:0] lft_r;
  logic [11:0] rght_r;
  logic [12:0] sum;
  logic [12:0] diff;
  logic [12:0] min_wt;
  logic [12:0] drop_wt;
  logic [25:0] tmr;
  logic        tmr_clr;
  logic        tmr_inc;
  logic        tmr_full;
  logic        sum_gt_min;
  logic        sum_lt_min;
  logic        diff_gt_1_4;
  logic        diff_gt_15_16;

  assign sum    = {1'b0, lft_r} + {1'b0, rght_r};
  assign diff   = (lft_r >= rght_r) ? {1'b0, lft_r - rght_r} : {1'b0, rght_r - lft_r};
  assign min_wt = {1'b0, MIN_RIDER_WT};

`ifdef STEER_HYST_EN
  assign drop_wt = min_wt - {1'b0, WT_HYSTERESIS};
`else
  // Single threshold: the hysteresis parameter stays on the interface but contributes nothing.
  assign drop_wt = min_wt - ({1'b0, WT_HYSTERESIS} & 13'd0);
`endif

  assign sum_gt_min    = (sum > min_wt);
  assign sum_lt_min    = (sum < drop_wt);
  assign diff_gt_1_4   = (diff > (sum >> 2));
  assign diff_gt_15_16 = (diff > (sum - (sum >> 4)));
  assign tmr_full      = fast_sim ? (&tmr[14:0]) : (&tmr);

  always_comb begin
    state_nxt = state;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (sum_gt_min) begin
          state_nxt = WAIT;
          tmr_clr   = 1'b1;
        end
      end
      WAIT: begin
        if (sum_lt_min)       state_nxt = IDLE;
        else if (diff_gt_1_4) tmr_clr   = 1'b1;
        else if (tmr_full)    state_nxt = STEER;
        else                  tmr_inc   = 1'b1;
      end
      STEER: begin
        if (sum_lt_min) begin
          state_nxt = IDLE;
        end else if (diff_gt_15_16) begin
          state_nxt = WAIT;
          tmr_clr   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state, so they always match the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lft_r       <= 12'd0;
      rght_r      <= 12'd0;
      tmr         <= 26'd0;
      rider_off   <= 1'b1;
      en_steer    <= 1'b0;
      steer_state <= 2'd0;
    end else begin
      if (ld_vld) begin
        lft_r  <= lft_ld;
        rght_r <= rght_ld;
      end
      if (tmr_clr)      tmr <= 26'd0;
      else if (tmr_inc) tmr <= tmr + 26'd1;
      state       <= state_nxt;
      rider_off   <= (state_nxt == IDLE);
      en_steer    <= (state_nxt == STEER);
      steer_state <= state_nxt;
    end
  end

endmodule

// File: doc/steer_en_ctrl.md
# steer_en_ctrl

Rider-presence and steering-enable sequencer for the balance controller. It samples the two platform load cells and runs a three-state machine with a settle timer. It produces `rider_off`, which clears and holds the PID integrator, and `en_steer`, which gates steer-pot differential drive in SegwayMath. It sits between the load-cell A2D interface and `balance_cntrl`.

## Interface
- `fast_sim`, default 1: settle timer terminal count is 2^15 cycles when 1, and 2^26 cycles (~1.34 s at 50 MHz) when 0.
- `MIN_RIDER_WT`, default 12'h200: minimum summed load that counts as a rider present.
- `WT_HYSTERESIS`, default 12'h40: drop-out margin below `MIN_RIDER_WT`.
- `clk` input 1: system clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ld_vld` input 1: single-cycle strobe; the load-cell values on this cycle are sampled.
- `lft_ld` input 12: left load cell reading, unsigned.
- `rght_ld` input 12: right load cell reading, unsigned.
- `rider_off` output 1: high when no rider is detected.
- `en_steer` output 1: high when steering is enabled.
- `steer_state` output 2: current state for debug; IDLE=0, WAIT=1, STEER=2.

## Operation
- Sample registers `lft_r` and `rght_r` load on `ld_vld`; all comparisons use the registered values.
- `sum` = `lft_r` + `rght_r`, 13 bits unsigned.
- `diff` = |`lft_r` − `rght_r`|, 12 bits unsigned.
- `sum_gt_min`: `sum` > `MIN_RIDER_WT` (strict).
- `sum_lt_min`: `sum` < `MIN_RIDER_WT` − `WT_HYSTERESIS` (strict); see Configuration.
- `diff_gt_1_4`: `diff` > `sum`>>2.
- `diff_gt_15_16`: `diff` > `sum` − (`sum`>>4). All operands are 13-bit unsigned.
- IDLE:
  - If `sum_gt_min`, go to WAIT and clear the timer; otherwise stay.
- WAIT:
  - If `sum_lt_min`, go to IDLE.
  - Else if `diff_gt_1_4`, clear the timer and stay.
  - Else if the timer is full, go to STEER.
  - Else increment the timer.
- STEER:
  - If `sum_lt_min`, go to IDLE.
  - Else if `diff_gt_15_16`, go to WAIT and clear the timer.
  - Otherwise stay.
- Priority within each state follows the order listed above.
- Timer: 26-bit up-counter, incremented only in WAIT with no clear condition active.
  - With `fast_sim`=1, the timer is full when `tmr[14:0]` is all ones.
  - With `fast_sim`=0, the timer is full when `tmr[25:0]` is all ones.
  - The counter never wraps, because reaching full forces an exit from WAIT.
- Outputs decode straight from the state register:
  - `rider_off` = (state==IDLE).
  - `en_steer` = (state==STEER).
  - There is no combinational path from any input to any output.

## Timing
- Reset values:
  - state IDLE, `rider_off`=1, `en_steer`=0, `steer_state`=0.
  - Timer, `lft_r` and `rght_r` all 0.
- Sample latency:
  - `ld_vld` at edge N loads the sample registers.
  - The resulting state change appears at edge N+1.
  - Outputs change on the same edge as the state.
- WAIT→STEER: `en_steer` rises exactly 2^15 cycles after WAIT is entered, or 2^26 cycles with `fast_sim`=0, provided no clear occurs.
- Between `ld_vld` strobes, the last sample is held and re-evaluated every cycle; the timer keeps counting.
- `ld_vld` held high samples every cycle.
- Equality boundaries do not trigger a transition:
  - `sum` == `MIN_RIDER_WT` stays in IDLE.
  - `sum` == `MIN_RIDER_WT` − `WT_HYSTERESIS` stays in the current state.
- Asserting `rst_n` low in any state immediately forces all reset values, independent of `clk`.

## Configuration
- `STEER_HYST_EN` defined: `sum_lt_min` uses `MIN_RIDER_WT` − `WT_HYSTERESIS`, as described in Operation.
- `STEER_HYST_EN` undefined: `sum_lt_min` = `sum` < `MIN_RIDER_WT`, so a single threshold is used and `WT_HYSTERESIS` is unused.
- All other behaviour is identical with and without the macro.

## Test plan
All scenarios use default parameters and `fast_sim`=1.
1. Assert `rst_n` low mid-simulation with random loads → `rider_off`=1, `en_steer`=0 and `steer_state`=0 asynchronously; the outputs hold through release.
2. `lft_ld`=`rght_ld`=12'h180 (sum 768, diff 0) with `ld_vld` pulsed once → `steer_state`=1 one edge later; `en_steer` rises exactly 32768 cycles after that.
3. In WAIT at timer ≈20000, apply `lft_ld`=12'h200, `rght_ld`=12'h100 (diff 256 > 192) → timer clears; `en_steer` needs a further full 32768 cycles of balanced load.
4. In STEER, apply `lft_ld`=12'h2F8, `rght_ld`=12'h008 (diff 752 > 720) → `en_steer` falls next edge, `steer_state`=1, `rider_off` stays 0.
5. In STEER with `STEER_HYST_EN` defined, apply `lft_ld`=`rght_ld`=12'h0F0 (sum 480) → stays in STEER; then apply 12'h0DC each (sum 440) → IDLE, `rider_off`=1. Without the macro, sum 480 → IDLE.
6. Boundary: `lft_ld`=`rght_ld`=12'h100 (sum exactly 512) in IDLE → remains IDLE indefinitely; changing `rght_ld` to 12'h101 → WAIT.
